// File: rtl/branch_pkg.sv
// Purpose: shared constants, types and the branch target table for branch_ctrl.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package branch_pkg;

  localparam logic [2:0] BR_OPC    = 3'b111;
  localparam int         LUT_DEPTH = 16;
  localparam int         ADDR_W    = 16;

  typedef enum logic [1:0] {BR_ALWAYS, BR_Z, BR_N, BR_CALLRET} br_cond_e;

  typedef enum logic {ST_RUN, ST_HALTED} br_state_e;

  // Instruction word as seen by the branch unit: opcode, condition, table index.
  typedef struct packed {
    logic [2:0] opc;
    br_cond_e   cond;
    logic [3:0] idx;
  } br_instr_t;

  // Constant jump targets; entry 0 sits in the least significant slot.
  localparam logic [LUT_DEPTH-1:0][ADDR_W-1:0] BR_LUT = {
    {13{16'h0000}}, 16'h01F7, 16'h0100, 16'h0010
  };

endpackage

// File: rtl/branch_ctrl_if.sv
// Purpose: groups the fetch/ALU/halt inputs and redirect outputs of branch_ctrl.
// Latency: n/a (wiring only).
// Backpressure: none; the branch unit always accepts the current instruction.
interface branch_ctrl_if;
  import branch_pkg::*;

  logic [8:0]        instr;
  logic [ADDR_W-1:0] PC;
  logic              alu_zero;
  logic              alu_neg;
  logic              flag_we;
  logic              halt_in;
  logic              jump_en;
  logic [ADDR_W-1:0] Target;
  logic [15:0]       taken_cnt;

  modport master (
    output instr, PC, alu_zero, alu_neg, flag_we, halt_in,
    input  jump_en, Target, taken_cnt
  );

  modport slave (
    input  instr, PC, alu_zero, alu_neg, flag_we, halt_in,
    output jump_en, Target, taken_cnt
  );

endinterface

// File: rtl/branch_ctrl_target_lut.sv
// Purpose: maps a 4-bit branch index to its constant 16-bit target address.
// Latency: combinational, zero cycles.
// Backpressure: none.
module target_lut
  import branch_pkg::*;
(
  input  logic [3:0]        idx,
  output logic [ADDR_W-1:0] addr
);

  assign addr = BR_LUT[idx];

endmodule

// File: rtl/branch_ctrl.sv
// Purpose: branch decision, flag register, RUN/HALTED FSM and taken-branch counter;
//          optional single-entry call/return link when BRANCH_CALL_RET_EN is defined.
// Latency: jump_en/Target combinational (same cycle); taken_cnt one cycle. Backpressure: none.
module branch_ctrl
  import branch_pkg::*;
(
  input  logic          CLK,
  input  logic          init,
  branch_ctrl_if.slave  bus
);

  br_instr_t         ins;
  logic [ADDR_W-1:0] lut_addr;
  logic              jump_c;
  logic [ADDR_W-1:0] target_c;
  logic              is_call;

  br_state_e         state_q, state_d;
  logic              z_q, z_d;
  logic              n_q, n_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] link_q;

  assign ins = br_instr_t'(bus.instr);

  target_lut u_lut (
    .idx  (ins.idx),
    .addr (lut_addr)
  );

`ifdef BRANCH_CALL_RET_EN
  logic [ADDR_W-1:0] link_d;
`else
  // Without call/return the link register does not exist, so PC has no reader.
  logic unused_pc;
  assign unused_pc = ^bus.PC;
  assign link_q    = '0;
`endif

  // Branch decision on registered flags only; reset and HALTED suppress any redirect.
  always_comb begin
    jump_c   = 1'b0;
    target_c = '0;
    is_call  = 1'b0;
    if (!init && state_q == ST_RUN && ins.opc == BR_OPC) begin
      case (ins.cond)
        BR_ALWAYS: jump_c = 1'b1;
        BR_Z:      jump_c = z_q;
        BR_N:      jump_c = n_q;
        BR_CALLRET: begin
`ifdef BRANCH_CALL_RET_EN
          jump_c  = 1'b1;
          is_call = (ins.idx != 4'hF);
`else
          jump_c  = 1'b0;
`endif
        end
        default:   jump_c = 1'b0;
      endcase
      if (jump_c) begin
        target_c = (ins.cond == BR_CALLRET && ins.idx == 4'hF) ? link_q : lut_addr;
      end
    end
  end

  assign bus.jump_en   = jump_c;
  assign bus.Target    = target_c;
  assign bus.taken_cnt = cnt_q;

  // Next-state: everything freezes in HALTED; a halt in RUN still lets this cycle's branch count.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
`ifdef BRANCH_CALL_RET_EN
    link_d  = link_q;
`endif
    if (state_q == ST_RUN) begin
      if (bus.flag_we) begin
        z_d = bus.alu_zero;
        n_d = bus.alu_neg;
      end
      if (jump_c && cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
`ifdef BRANCH_CALL_RET_EN
      if (is_call) begin
        link_d = bus.PC + 16'd1;
      end
`endif
      if (bus.halt_in) begin
        state_d = ST_HALTED;
      end
    end
  end

  // All state in one register block; init overrides every other update in its cycle.
  always_ff @(posedge CLK) begin
    if (init) begin
      state_q <= ST_RUN;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      cnt_q   <= '0;
`ifdef BRANCH_CALL_RET_EN
      link_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
`ifdef BRANCH_CALL_RET_EN
      link_q  <= link_d;
`endif
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Purpose: directed scenarios plus random stimulus against a behavioural model of branch_ctrl.
// Latency: checks redirect outputs in the issuing cycle, taken_cnt one cycle later.
// Backpressure: none; one instruction presented per cycle.
module tb_branch_ctrl;

  logic CLK = 1'b0;
  logic init;
  int   checks = 0;
  int   errors = 0;

  branch_ctrl_if bif ();

  branch_ctrl dut (
    .CLK  (CLK),
    .init (init),
    .bus  (bif.slave)
  );

  always #5 CLK = ~CLK;

  // Behavioural model state
  logic [15:0] lut [16];
  bit          m_z, m_n, m_halted;
  logic [15:0] m_link;
  int          m_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one instruction for one cycle, check outputs mid-cycle, then advance the model.
  task automatic step(input bit i_init, input logic [8:0] i_instr, input logic [15:0] i_pc,
                      input bit i_z, input bit i_n, input bit i_we, input bit i_halt,
                      input bit do_chk, input string tag);
    bit          e_j;
    bit          call;
    logic [15:0] e_t;
    logic [1:0]  cond;
    logic [3:0]  idx;
    init         = i_init;
    bif.instr    = i_instr;
    bif.PC       = i_pc;
    bif.alu_zero = i_z;
    bif.alu_neg  = i_n;
    bif.flag_we  = i_we;
    bif.halt_in  = i_halt;
    #4;
    cond = i_instr[5:4];
    idx  = i_instr[3:0];
    e_j  = 1'b0;
    call = 1'b0;
    e_t  = 16'h0000;
    if (!i_init && !m_halted && i_instr[8:6] == 3'b111) begin
      if (cond == 2'd0) e_j = 1'b1;
      else if (cond == 2'd1) e_j = m_z;
      else if (cond == 2'd2) e_j = m_n;
      else begin
`ifdef BRANCH_CALL_RET_EN
        e_j  = 1'b1;
        call = (idx != 4'hF);
`endif
      end
      if (e_j) e_t = (cond == 2'd3 && idx == 4'hF) ? m_link : lut[idx];
    end
    if (do_chk) begin
      chk({tag, "_jump"}, {15'd0, bif.jump_en}, {15'd0, e_j});
      chk({tag, "_target"}, bif.Target, e_t);
      chk({tag, "_cnt"}, bif.taken_cnt, m_cnt[15:0]);
    end
    @(posedge CLK);
    #1;
    if (i_init) begin
      m_z = 0; m_n = 0; m_link = 16'h0000; m_cnt = 0; m_halted = 0;
    end else if (!m_halted) begin
      if (e_j && m_cnt < 65535) m_cnt++;
      if (i_we) begin m_z = i_z; m_n = i_n; end
      if (call) m_link = i_pc + 16'd1;
      if (i_halt) m_halted = 1;
    end
  endtask

  initial begin
    logic [8:0]  r_instr;
    logic [15:0] r_pc;
    for (int i = 0; i < 16; i++) lut[i] = 16'h0000;
    lut[0] = 16'h0010;
    lut[1] = 16'h0100;
    lut[2] = 16'h01F7;
    m_z = 0; m_n = 0; m_halted = 0; m_link = 0; m_cnt = 0;
    init = 1'b1;
    bif.instr = '0; bif.PC = '0; bif.alu_zero = 0; bif.alu_neg = 0;
    bif.flag_we = 0; bif.halt_in = 0;
    @(posedge CLK);
    #1;

    // Reset state: init pulse, then a second init cycle with a taken branch presented
    step(1, 9'b111_00_0000, 16'd0, 0, 0, 0, 0, 0, "rst0");
    step(1, 9'b111_00_0000, 16'd0, 0, 0, 0, 0, 1, "rst1");

    // Unconditional branch to entry 1
    step(0, 9'b111_00_0001, 16'd5, 0, 0, 0, 0, 1, "uncond");
    chk("uncond_cnt_next", bif.taken_cnt, 16'd1);

    // Flag write coinciding with a Z branch uses old flags
    step(0, 9'b111_01_0000, 16'd6, 1, 0, 1, 0, 1, "zcoinc");
    step(0, 9'b111_01_0000, 16'd7, 0, 0, 0, 0, 1, "zrepeat");
    step(0, 9'b111_10_0010, 16'd8, 0, 1, 1, 0, 1, "ncoinc");
    step(0, 9'b111_10_0010, 16'd9, 0, 0, 0, 0, 1, "nrepeat");
    step(0, 9'b010_00_0001, 16'd10, 0, 0, 0, 0, 1, "nonbr");

    // Call / return (no-op without the macro)
    step(0, 9'b111_11_0010, 16'h0020, 0, 0, 0, 0, 1, "call");
    step(0, 9'b111_11_1111, 16'h0030, 0, 0, 0, 0, 1, "ret");
    step(0, 9'b111_11_0000, 16'hFFFF, 0, 0, 0, 0, 1, "callwrap");
    step(0, 9'b111_11_1111, 16'h0001, 0, 0, 0, 0, 1, "retwrap");

    // Halt freezes everything until init
    step(0, 9'b000_00_0000, 16'd20, 0, 0, 0, 1, 1, "halt");
    step(0, 9'b111_00_0000, 16'd21, 1, 1, 1, 0, 1, "halted1");
    step(0, 9'b111_01_0000, 16'd22, 0, 0, 0, 0, 1, "halted2");
    step(1, 9'b000_00_0000, 16'd0, 0, 0, 0, 0, 1, "unhalt");
    step(0, 9'b111_00_0000, 16'd23, 0, 0, 0, 0, 1, "afterinit");

    // Halt together with a taken branch still counts that branch
    step(0, 9'b111_00_0010, 16'd24, 0, 0, 0, 1, 1, "haltbr");
    step(0, 9'b111_00_0010, 16'd25, 0, 0, 0, 0, 1, "haltbr_next");

    // init beats halt and branch in the same cycle
    step(1, 9'b111_00_0000, 16'd26, 1, 1, 1, 1, 1, "initprio");
    chk("initprio_cnt", bif.taken_cnt, 16'd0);
    step(0, 9'b111_00_0000, 16'd27, 0, 0, 0, 0, 1, "initprio_run");

    // Random stimulus against the model
    for (int i = 0; i < 2000; i++) begin
      r_instr = 9'($urandom);
      if ($urandom_range(0, 9) < 6) r_instr[8:6] = 3'b111;
      r_pc = 16'($urandom);
      step(($urandom_range(0, 99) < 2), r_instr, r_pc, 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 99) < 3), 1, "rand");
    end

    // Counter saturation
    step(1, 9'b000_00_0000, 16'd0, 0, 0, 0, 0, 0, "satinit");
    for (int i = 0; i < 65534; i++) begin
      step(0, 9'b111_00_0000, 16'd0, 0, 0, 0, 0, 0, "satfill");
    end
    chk("sat_fffe", bif.taken_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step(0, 9'b111_00_0000, 16'd0, 0, 0, 0, 0, 1, "sat");
    end
    chk("sat_ffff", bif.taken_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: none; all constants come from branch_pkg.
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 init  input  1  synchronous active-high reset.
REQ-004 instr  input  9  instruction currently fetched at PC.
REQ-005 PC  input  16  current program counter value.
REQ-006 alu_zero  input  1  ALU zero result for the current instruction.
REQ-007 alu_neg  input  1  ALU negative result for the current instruction.
REQ-008 flag_we  input  1  capture alu_zero/alu_neg into the flag register.
REQ-009 halt_in  input  1  halt indication from the program counter.
REQ-010 jump_en  output  1  redirect the program counter this cycle; combinational.
REQ-011 Target  output  16  redirect address; combinational, valid when jump_en=1, otherwise 0.
REQ-012 taken_cnt  output  16  registered count of taken branches.

Function
REQ-013 A branch is an instruction with instr[8:6]==3'b111; cond=instr[5:4]; idx=instr[3:0].
REQ-014 cond 00 is always taken, 01 is taken if Z_q=1, and 10 is taken if N_q=1.
REQ-015 A taken branch drives jump_en=1 and Target=LUT[idx] in the same cycle, with zero latency, so the PC loads Target at the next edge.
REQ-016 Branches evaluate the registered flags only; when flag_we and a branch coincide, the branch uses the old flags and the new flags are visible from the next cycle.
REQ-017 Flag register: when flag_we=1, Z_q<=alu_zero and N_q<=alu_neg; otherwise Z_q and N_q hold.
REQ-018 The FSM has two states, RUN and HALTED. RUN->HALTED on a cycle with halt_in=1 and init=0. HALTED->RUN only on init.
REQ-019 In HALTED: jump_en=0, Target=0, the flags, link and taken_cnt are frozen, and flag_we is ignored.
REQ-020 A halt_in in the same cycle as a taken branch still produces jump_en=1 for that cycle, and the branch is counted.
REQ-021 taken_cnt increments by 1 on each posedge where jump_en=1, and saturates at 16'hFFFF with no wrap.
REQ-022 A non-branch opcode, or cond 11 with CALL_RET_EN undefined, drives jump_en=0 and Target=0.

Reset
REQ-023 While init=1: jump_en=0 and Target=0 combinationally.
REQ-024 At the edge where init=1: Z_q=0, N_q=0, link=0, taken_cnt=0, and state=RUN.
REQ-025 An init asserted mid-program takes priority over halt_in, flag_we and any branch in the same cycle.

Configuration
REQ-026 Macro BRANCH_CALL_RET_EN.
REQ-027 With BRANCH_CALL_RET_EN defined, cond 11 with idx!=4'hF is a call: it is always taken, Target=LUT[idx], and link<=PC+1 (16-bit, wraps at 16'hFFFF to 0).
REQ-028 With BRANCH_CALL_RET_EN defined, cond 11 with idx==4'hF is a return: it is always taken and Target=link.
REQ-029 The link register is single-entry; a nested call overwrites it.
REQ-030 Without BRANCH_CALL_RET_EN, the link register is absent and cond 11 is a no-op per REQ-022.

Structure
REQ-031 branch_pkg holds the following:
- BR_OPC=3'b111;
- cond enum {BR_ALWAYS, BR_Z, BR_N, BR_CALLRET};
- LUT_DEPTH=16;
- ADDR_W=16;
- the constant target table. Entry 0=16'h0010, entry 1=16'h0100, entry 2=16'h01F7, and entries 3-15=16'h0000.
REQ-032 One sub-module, target_lut, is combinational: it maps idx[3:0] to a 16-bit address from the package table. branch_ctrl holds all sequential state.

Verification
REQ-033 Scenario: init, then instr=9'b111_00_0001 at PC=5 -> same cycle jump_en=1, Target=16'h0100; next cycle taken_cnt=1.
REQ-034 Scenario: flag_we=1 with alu_zero=1 and instr=9'b111_01_0000 in the same cycle -> jump_en=0 that cycle; the same branch repeated next cycle -> jump_en=1, Target=16'h0010.
REQ-035 Scenario: with BRANCH_CALL_RET_EN defined, call 9'b111_11_0010 at PC=16'h0020 -> Target=16'h01F7; then return 9'b111_11_1111 -> Target=16'h0021. Without BRANCH_CALL_RET_EN, the same instructions -> jump_en=0.
REQ-036 Scenario: halt_in=1 for one cycle, then instr=9'b111_00_0000 -> jump_en=0 and taken_cnt frozen until init; after init -> jump_en=1.
REQ-037 Scenario: force taken_cnt to 16'hFFFE, then three taken branches -> taken_cnt reads 16'hFFFF and stays there.
REQ-038 Scenario: init=1 together with halt_in=1 and a taken branch -> jump_en=0; next cycle state=RUN and taken_cnt=0.
